// File: rtl/alu_stage.sv
// alu_stage: execute stage of the five-stage pipeline.
// Registers one decoded instruction per cycle, computes the ALU result (also
// the memory address), forwards memory controls and store data, and owns the
// HI/LO registers together with a 32-iteration restoring divider.
// Optional feature macro: ALU_STAGE_MULT_EN enables single-cycle MULT/MULTU.
module alu_stage #(
  parameter logic [31:0] HILO_RESET = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        in_valid,
  input  logic [4:0]  alu_op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        in_mem_read,
  input  logic        in_mem_write,
  input  logic [31:0] in_store_data,
  input  logic [4:0]  in_rd,
  input  logic        in_reg_write,
  output logic [31:0] alu_result,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] write_data,
  output logic [4:0]  out_rd,
  output logic        out_reg_write,
  output logic        out_valid,
  output logic        overflow_exc,
  output logic        busy
);

  typedef enum logic [4:0] {
    OP_ADD   = 5'd0,  OP_ADDU  = 5'd1,  OP_SUB   = 5'd2,  OP_SUBU  = 5'd3,
    OP_AND   = 5'd4,  OP_OR    = 5'd5,  OP_XOR   = 5'd6,  OP_NOR   = 5'd7,
    OP_SLT   = 5'd8,  OP_SLTU  = 5'd9,  OP_SLL   = 5'd10, OP_SRL   = 5'd11,
    OP_SRA   = 5'd12, OP_LUI   = 5'd13, OP_DIVU  = 5'd14, OP_DIV   = 5'd15,
    OP_MFHI  = 5'd16, OP_MFLO  = 5'd17, OP_MTHI  = 5'd18, OP_MTLO  = 5'd19,
    OP_MULTU = 5'd20, OP_MULT  = 5'd21
  } op_e;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_RUN  = 2'd1,
    DIV_FIX  = 2'd2
  } div_state_e;

  op_e         op;
  logic        accept;

  logic [31:0] hi, lo;

  div_state_e  div_state;
  logic [4:0]  div_cnt;
  logic [31:0] div_rem;
  logic [31:0] div_quo;
  logic [31:0] div_dvs;
  logic        div_neg_q;
  logic        div_neg_r;

  // Decoded per-instruction effects
  logic [31:0] result;
  logic        ovf;
  logic        issue;
  logic        div_start;
  logic        div_signed;
  logic        hi_wr, lo_wr;
  logic [31:0] hi_new, lo_new;
  logic [31:0] sum, diff;

  // Divider operand preparation and one restoring step
  logic        neg_a, neg_b;
  logic [31:0] abs_a, abs_b;
  logic [32:0] rem_sh, rem_try;

`ifdef ALU_STAGE_MULT_EN
  logic [63:0] prod_u, prod_s;
`endif

  assign op     = op_e'(alu_op);
  // The divider owns HI/LO while running, so nothing is accepted then.
  assign accept = in_valid & ~busy & ~stall & ~flush;

  assign sum  = src_a + src_b;
  assign diff = src_a - src_b;

  assign neg_a = div_signed & src_a[31];
  assign neg_b = div_signed & src_b[31];
  assign abs_a = neg_a ? (~src_a + 32'd1) : src_a;
  assign abs_b = neg_b ? (~src_b + 32'd1) : src_b;

  // Shift the next dividend bit into the partial remainder and trial-subtract;
  // bit 32 of the trial is the borrow (remainder smaller than divisor).
  assign rem_sh  = {div_rem, div_quo[31]};
  assign rem_try = rem_sh - {1'b0, div_dvs};

`ifdef ALU_STAGE_MULT_EN
  assign prod_u = {32'd0, src_a} * {32'd0, src_b};
  assign prod_s = {{32{src_a[31]}}, src_a} * {{32{src_b[31]}}, src_b};
`endif

  // Decode the operation into a result, trap flag and HI/LO side effects.
  always_comb begin
    // NOTE: every output of this block gets a default first so that no
    // path through the case can leave one unassigned and infer a latch.
    result     = '0;
    ovf        = 1'b0;
    issue      = 1'b1;
    div_start  = 1'b0;
    div_signed = 1'b0;
    hi_wr      = 1'b0;
    lo_wr      = 1'b0;
    hi_new     = src_a;
    lo_new     = src_a;
    case (op)
      OP_ADD: begin
        result = sum;
        ovf    = (src_a[31] == src_b[31]) && (sum[31] != src_a[31]);
      end
      OP_ADDU: result = sum;
      OP_SUB: begin
        result = diff;
        ovf    = (src_a[31] != src_b[31]) && (diff[31] != src_a[31]);
      end
      OP_SUBU: result = diff;
      OP_AND:  result = src_a & src_b;
      OP_OR:   result = src_a | src_b;
      OP_XOR:  result = src_a ^ src_b;
      OP_NOR:  result = ~(src_a | src_b);
      OP_SLT:  result = {31'd0, $signed(src_a) < $signed(src_b)};
      OP_SLTU: result = {31'd0, src_a < src_b};
      OP_SLL:  result = src_b << src_a[4:0];
      OP_SRL:  result = src_b >> src_a[4:0];
      OP_SRA:  result = $signed(src_b) >>> src_a[4:0];
      OP_LUI:  result = {src_b[15:0], 16'd0};
      OP_DIVU: begin
        issue     = 1'b0;
        div_start = 1'b1;
      end
      OP_DIV: begin
        issue      = 1'b0;
        div_start  = 1'b1;
        div_signed = 1'b1;
      end
      OP_MFHI: result = hi;
      OP_MFLO: result = lo;
      OP_MTHI: begin
        issue = 1'b0;
        hi_wr = 1'b1;
      end
      OP_MTLO: begin
        issue = 1'b0;
        lo_wr = 1'b1;
      end
`ifdef ALU_STAGE_MULT_EN
      OP_MULTU: begin
        issue  = 1'b0;
        hi_wr  = 1'b1;
        lo_wr  = 1'b1;
        hi_new = prod_u[63:32];
        lo_new = prod_u[31:0];
      end
      OP_MULT: begin
        issue  = 1'b0;
        hi_wr  = 1'b1;
        lo_wr  = 1'b1;
        hi_new = prod_s[63:32];
        lo_new = prod_s[31:0];
      end
`endif
      default: issue = 1'b0;
    endcase
  end

  // Output pipeline register: hold on stall, load on accept, else a bubble.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    if (!reset) begin
      alu_result    <= '0;
      mem_read      <= 1'b0;
      mem_write     <= 1'b0;
      write_data    <= '0;
      out_rd        <= '0;
      out_reg_write <= 1'b0;
      out_valid     <= 1'b0;
      overflow_exc  <= 1'b0;
    end else if (!stall) begin
      if (accept) begin
        alu_result    <= result;
        write_data    <= in_store_data;
        out_rd        <= in_rd;
        out_valid     <= issue;
        overflow_exc  <= ovf;
        // A trapping instruction must not touch memory or the register file.
        mem_read      <= issue & in_mem_read & ~ovf;
        mem_write     <= issue & in_mem_write & ~ovf;
        out_reg_write <= issue & in_reg_write & ~ovf;
      end else begin
        mem_read      <= 1'b0;
        mem_write     <= 1'b0;
        out_reg_write <= 1'b0;
        out_valid     <= 1'b0;
        overflow_exc  <= 1'b0;
      end
    end
  end

  // HI/LO ownership and the divider FSM; runs independently of stall/flush.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi        <= HILO_RESET;
      lo        <= HILO_RESET;
      div_state <= DIV_IDLE;
      div_cnt   <= '0;
      div_rem   <= '0;
      div_quo   <= '0;
      div_dvs   <= '0;
      div_neg_q <= 1'b0;
      div_neg_r <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (div_state)
        DIV_IDLE: begin
          if (accept && div_start) begin
            div_rem   <= '0;
            div_quo   <= abs_a;
            div_dvs   <= abs_b;
            // Quotient sign follows operand signs; remainder follows dividend.
            div_neg_q <= neg_a ^ neg_b;
            div_neg_r <= neg_a;
            div_cnt   <= '0;
            div_state <= DIV_RUN;
            busy      <= 1'b1;
          end else if (accept) begin
            if (hi_wr) hi <= hi_new;
            if (lo_wr) lo <= lo_new;
          end
        end
        DIV_RUN: begin
          if (!rem_try[32]) begin
            div_rem <= rem_try[31:0];
            div_quo <= {div_quo[30:0], 1'b1};
          end else begin
            div_rem <= rem_sh[31:0];
            div_quo <= {div_quo[30:0], 1'b0};
          end
          div_cnt <= div_cnt + 5'd1;
          if (div_cnt == 5'd31) div_state <= DIV_FIX;
        end
        DIV_FIX: begin
          // A zero divisor yields all-ones quotient and remainder = |dividend|,
          // so the sign fix-up alone produces the divide-by-zero results.
          hi        <= div_neg_r ? (~div_rem + 32'd1) : div_rem;
          lo        <= div_neg_q ? (~div_quo + 32'd1) : div_quo;
          div_state <= DIV_IDLE;
          busy      <= 1'b0;
        end
        default: begin
          div_state <= DIV_IDLE;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_stage.sv
// tb_alu_stage: directed test of alu_stage against a behavioural model.
// Build with +define+ALU_STAGE_MULT_EN to exercise the multiplier option.
module tb_alu_stage;

  localparam logic [31:0] HILO = 32'h0000_0000;

  localparam logic [4:0] ADD = 5'd0,  ADDU = 5'd1,  SUB = 5'd2,  SUBU = 5'd3;
  localparam logic [4:0] AND_ = 5'd4, OR_ = 5'd5,  XOR_ = 5'd6, NOR_ = 5'd7;
  localparam logic [4:0] SLT = 5'd8,  SLTU = 5'd9,  SLL = 5'd10, SRL = 5'd11;
  localparam logic [4:0] SRA = 5'd12, LUI = 5'd13, DIVU = 5'd14, DIV = 5'd15;
  localparam logic [4:0] MFHI = 5'd16, MFLO = 5'd17, MTHI = 5'd18, MTLO = 5'd19;
  localparam logic [4:0] MULTU = 5'd20, MULT = 5'd21;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [4:0]  alu_op = '0;
  logic [31:0] src_a = '0;
  logic [31:0] src_b = '0;
  logic        in_mem_read = 1'b0;
  logic        in_mem_write = 1'b0;
  logic [31:0] in_store_data = '0;
  logic [4:0]  in_rd = '0;
  logic        in_reg_write = 1'b0;
  logic [31:0] alu_result;
  logic        mem_read, mem_write;
  logic [31:0] write_data;
  logic [4:0]  out_rd;
  logic        out_reg_write, out_valid, overflow_exc, busy;

  int n_checks = 0;
  int n_errors = 0;
  logic en_cmp = 1'b0;

  // Model state
  logic        e_valid = 1'b0, e_mr = 1'b0, e_mw = 1'b0, e_rw = 1'b0, e_ovf = 1'b0;
  logic [31:0] e_res = '0, e_wd = '0;
  logic [4:0]  e_rd = '0;
  logic [31:0] m_hi = HILO, m_lo = HILO, p_hi = '0, p_lo = '0;
  int          div_left = 0;

  alu_stage #(.HILO_RESET(HILO)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .in_valid(in_valid), .alu_op(alu_op), .src_a(src_a), .src_b(src_b),
    .in_mem_read(in_mem_read), .in_mem_write(in_mem_write),
    .in_store_data(in_store_data), .in_rd(in_rd), .in_reg_write(in_reg_write),
    .alu_result(alu_result), .mem_read(mem_read), .mem_write(mem_write),
    .write_data(write_data), .out_rd(out_rd), .out_reg_write(out_reg_write),
    .out_valid(out_valid), .overflow_exc(overflow_exc), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    check(name, {31'd0, act}, {31'd0, exp});
  endtask

  // Quotient/remainder straight from the division rules, using SV arithmetic.
  task automatic model_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] q, output logic [31:0] r);
    int sa, sb;
    sa = int'(a);
    sb = int'(b);
    if (b == 32'd0) begin
      r = a;
      q = (sgn && a[31]) ? 32'd1 : 32'hFFFF_FFFF;
    end else if (!sgn) begin
      q = a / b;
      r = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'd0;
    end else begin
      q = 32'(sa / sb);
      r = 32'(sa % sb);
    end
  endtask

  // Behavioural model: what the stage must present after each edge.
  always @(posedge clk or negedge reset) begin : model
    logic        acc, v, ov;
    logic [31:0] r;
    longint      s;
    logic [63:0] pr;
    if (!reset) begin
      e_valid = 1'b0; e_mr = 1'b0; e_mw = 1'b0; e_rw = 1'b0; e_ovf = 1'b0;
      e_res = '0; e_wd = '0; e_rd = '0;
      m_hi = HILO; m_lo = HILO; div_left = 0;
    end else begin
      acc = in_valid && (div_left == 0) && !stall && !flush;
      if (div_left > 0) begin
        div_left--;
        if (div_left == 0) begin
          m_hi = p_hi;
          m_lo = p_lo;
        end
      end
      if (!stall) begin
        if (acc) begin
          v = 1'b1; ov = 1'b0; r = '0;
          case (alu_op)
            ADD: begin
              s  = longint'($signed(src_a)) + longint'($signed(src_b));
              r  = s[31:0];
              ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            ADDU: r = src_a + src_b;
            SUB: begin
              s  = longint'($signed(src_a)) - longint'($signed(src_b));
              r  = s[31:0];
              ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            SUBU: r = src_a - src_b;
            AND_: r = src_a & src_b;
            OR_:  r = src_a | src_b;
            XOR_: r = src_a ^ src_b;
            NOR_: r = ~(src_a | src_b);
            SLT:  r = ($signed(src_a) < $signed(src_b)) ? 32'd1 : 32'd0;
            SLTU: r = (src_a < src_b) ? 32'd1 : 32'd0;
            SLL:  r = src_b << src_a[4:0];
            SRL:  r = src_b >> src_a[4:0];
            SRA:  r = $signed(src_b) >>> src_a[4:0];
            LUI:  r = src_b << 16;
            DIVU: begin v = 1'b0; model_div(1'b0, src_a, src_b, p_lo, p_hi); div_left = 33; end
            DIV:  begin v = 1'b0; model_div(1'b1, src_a, src_b, p_lo, p_hi); div_left = 33; end
            MFHI: r = m_hi;
            MFLO: r = m_lo;
            MTHI: begin v = 1'b0; m_hi = src_a; end
            MTLO: begin v = 1'b0; m_lo = src_a; end
`ifdef ALU_STAGE_MULT_EN
            MULTU: begin
              v = 1'b0;
              pr = 64'(src_a) * 64'(src_b);
              m_hi = pr[63:32]; m_lo = pr[31:0];
            end
            MULT: begin
              v = 1'b0;
              pr = 64'(longint'($signed(src_a)) * longint'($signed(src_b)));
              m_hi = pr[63:32]; m_lo = pr[31:0];
            end
`endif
            default: v = 1'b0;
          endcase
          e_valid = v;
          e_ovf   = ov;
          e_res   = r;
          e_wd    = in_store_data;
          e_rd    = in_rd;
          e_mr    = v && !ov && in_mem_read;
          e_mw    = v && !ov && in_mem_write;
          e_rw    = v && !ov && in_reg_write;
        end else begin
          e_valid = 1'b0; e_mr = 1'b0; e_mw = 1'b0; e_rw = 1'b0; e_ovf = 1'b0;
        end
      end
    end
  end

  // Compare DUT against the model every cycle, away from the rising edge.
  always @(negedge clk) begin
    if (en_cmp) begin
      chk1("cmp_busy", busy, div_left > 0);
      chk1("cmp_valid", out_valid, e_valid);
      chk1("cmp_mem_read", mem_read, e_mr);
      chk1("cmp_mem_write", mem_write, e_mw);
      chk1("cmp_reg_write", out_reg_write, e_rw);
      chk1("cmp_ovf", overflow_exc, e_ovf);
      if (e_valid) begin
        check("cmp_result", alu_result, e_res);
        check("cmp_wdata", write_data, e_wd);
        check("cmp_rd", {27'd0, out_rd}, {27'd0, e_rd});
      end
    end
  end

  task automatic drive(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic mr, input logic mw, input logic [31:0] sd,
                       input logic [4:0] rd, input logic rw);
    in_valid = 1'b1; alu_op = op; src_a = a; src_b = b;
    in_mem_read = mr; in_mem_write = mw; in_store_data = sd;
    in_rd = rd; in_reg_write = rw;
  endtask

  task automatic tick();
    @(negedge clk);
    in_valid = 1'b0;
    flush = 1'b0;
  endtask

  task automatic alu(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    drive(op, a, b, 1'b0, 1'b0, 32'd0, 5'd2, 1'b1);
    tick();
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic do_div(input string name, input logic [4:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_lo,
                        input logic [31:0] exp_hi);
    int n;
    drive(op, a, b, 1'b0, 1'b0, 32'd0, 5'd4, 1'b1);
    tick();
    chk1({name, "_bubble"}, out_valid, 1'b0);
    wait_idle(n);
    check({name, "_busy_cycles"}, n, 33);
    alu(MFLO, 32'd0, 32'd0);
    check({name, "_lo"}, alu_result, exp_lo);
    alu(MFHI, 32'd0, 32'd0);
    check({name, "_hi"}, alu_result, exp_hi);
  endtask

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[12] = '{
    '{AND_, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000},
    '{OR_,  32'hF0F0_F0F0, 32'h0F0F_0000, 32'hFFFF_F0F0},
    '{XOR_, 32'hFFFF_0000, 32'hF0F0_F0F0, 32'h0F0F_F0F0},
    '{NOR_, 32'h0F0F_0F0F, 32'hF0F0_F000, 32'h0000_00F0},
    '{SLT,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001},
    '{SLTU, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000},
    '{SLL,  32'h0000_0004, 32'h0000_0001, 32'h0000_0010},
    '{SRL,  32'h0000_0004, 32'h8000_0000, 32'h0800_0000},
    '{SRA,  32'h0000_0004, 32'h8000_0000, 32'hF800_0000},
    '{LUI,  32'h0000_0000, 32'h0000_1234, 32'h1234_0000},
    '{ADD,  32'h0000_0005, 32'hFFFF_FFFD, 32'h0000_0002},
    '{SUBU, 32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE}
  };

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    int n;
    // Reset
    @(posedge clk); #2;
    en_cmp = 1'b1;
    @(negedge clk);
    chk1("rst_valid", out_valid, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    check("rst_result", alu_result, 32'd0);
    chk1("rst_ovf", overflow_exc, 1'b0);
    @(posedge clk); #2 reset = 1'b1;
    @(negedge clk);

    // Signed overflow traps, unsigned wraps
    alu(ADD, 32'h7FFF_FFFF, 32'd1);
    chk1("add_ovf_exc", overflow_exc, 1'b1);
    chk1("add_ovf_rw", out_reg_write, 1'b0);
    chk1("add_ovf_valid", out_valid, 1'b1);
    alu(ADDU, 32'h7FFF_FFFF, 32'd1);
    check("addu_result", alu_result, 32'h8000_0000);
    chk1("addu_rw", out_reg_write, 1'b1);
    chk1("addu_ovf", overflow_exc, 1'b0);
    drive(ADD, 32'h7FFF_FFFF, 32'd1, 1'b0, 1'b1, 32'h55, 5'd0, 1'b0);
    tick();
    chk1("ovf_store_mw", mem_write, 1'b0);
    alu(SUB, 32'h8000_0000, 32'd1);
    chk1("sub_ovf_exc", overflow_exc, 1'b1);

    // Load address, then stall holds it for three cycles
    drive(ADDU, 32'h100, 32'h4, 1'b1, 1'b0, 32'd0, 5'd8, 1'b1);
    tick();
    check("load_addr", alu_result, 32'h104);
    chk1("load_mr", mem_read, 1'b1);
    stall = 1'b1;
    drive(ADDU, 32'd1, 32'd1, 1'b0, 1'b1, 32'd9, 5'd9, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_addr", alu_result, 32'h104);
      chk1("stall_mr", mem_read, 1'b1);
      check("stall_rd", {27'd0, out_rd}, 32'd8);
    end
    stall = 1'b0;
    in_valid = 1'b0;
    tick();
    chk1("post_stall_bubble", out_valid, 1'b0);

    // Logic, compare, shift and LUI vectors
    foreach (vecs[i]) begin
      alu(vecs[i].op, vecs[i].a, vecs[i].b);
      check($sformatf("vec%0d_op%0d", i, vecs[i].op), alu_result, vecs[i].exp);
    end

    // HI/LO moves
    alu(MTHI, 32'hDEAD_BEEF, 32'd0);
    chk1("mthi_bubble", out_valid, 1'b0);
    alu(MTLO, 32'h1234_5678, 32'd0);
    alu(MFHI, 32'd0, 32'd0);
    check("mfhi", alu_result, 32'hDEAD_BEEF);
    alu(MFLO, 32'd0, 32'd0);
    check("mflo", alu_result, 32'h1234_5678);

    // DIVU with new instructions offered (and ignored) while busy
    drive(DIVU, 32'd100, 32'd7, 1'b0, 1'b0, 32'd0, 5'd4, 1'b1);
    tick();
    drive(ADDU, 32'd1, 32'd2, 1'b0, 1'b0, 32'd0, 5'd5, 1'b1);
    wait_idle(n);
    in_valid = 1'b0;
    check("divu_busy_cycles", n, 33);
    alu(MFLO, 32'd0, 32'd0);
    check("divu_lo", alu_result, 32'd14);
    alu(MFHI, 32'd0, 32'd0);
    check("divu_hi", alu_result, 32'd2);

    // DIV with a downstream stall in the middle: divider keeps running
    drive(DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, 32'd0, 5'd4, 1'b1);
    tick();
    stall = 1'b1;
    repeat (5) @(negedge clk);
    stall = 1'b0;
    wait_idle(n);
    check("div_stall_busy_cycles", n + 5, 33);
    alu(MFLO, 32'd0, 32'd0);
    check("div_neg_lo", alu_result, 32'hFFFF_FFFD);
    alu(MFHI, 32'd0, 32'd0);
    check("div_neg_hi", alu_result, 32'hFFFF_FFFF);

    do_div("div_by0", DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5);
    do_div("div_minint", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0);
    do_div("div_negby0", DIV, 32'hFFFF_FFF8, 32'd0, 32'd1, 32'hFFFF_FFF8);
    do_div("divu_by0", DIVU, 32'd9, 32'd0, 32'hFFFF_FFFF, 32'd9);
    do_div("div_negdiv", DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1);
    do_div("divu_big", DIVU, 32'hFFFF_FFFF, 32'd16, 32'h0FFF_FFFF, 32'd15);

    // Reset in the tenth busy cycle aborts the divide
    drive(DIV, 32'd100, 32'd3, 1'b0, 1'b0, 32'd0, 5'd4, 1'b1);
    tick();
    repeat (9) @(negedge clk);
    chk1("abort_busy_before", busy, 1'b1);
    @(posedge clk); #2 reset = 1'b0;
    #1 chk1("abort_busy_async", busy, 1'b0);
    @(posedge clk); #2 reset = 1'b1;
    @(negedge clk);
    chk1("abort_busy_after", busy, 1'b0);
    alu(MFHI, 32'd0, 32'd0);
    check("abort_hi", alu_result, HILO);
    alu(MFLO, 32'd0, 32'd0);
    check("abort_lo", alu_result, HILO);
    alu(ADDU, 32'd2, 32'd3);
    check("abort_addu", alu_result, 32'd5);
    chk1("abort_addu_valid", out_valid, 1'b1);

    // Flushed store is squashed; the same store unflushed goes through
    drive(ADDU, 32'h200, 32'h8, 1'b0, 1'b1, 32'hCAFE, 5'd0, 1'b0);
    flush = 1'b1;
    tick();
    chk1("flush_valid", out_valid, 1'b0);
    chk1("flush_mw", mem_write, 1'b0);
    drive(ADDU, 32'h200, 32'h8, 1'b0, 1'b1, 32'hCAFE, 5'd0, 1'b0);
    tick();
    chk1("sw_mw", mem_write, 1'b1);
    check("sw_addr", alu_result, 32'h208);
    check("sw_data", write_data, 32'hCAFE);

    // Undefined opcode is a bubble
    alu(5'd25, 32'd1, 32'd1);
    chk1("undef_bubble", out_valid, 1'b0);

    // Multiply (or bubble when the option is absent)
    alu(MTHI, 32'h11, 32'd0);
    alu(MTLO, 32'h22, 32'd0);
    alu(MULTU, 32'h0001_0000, 32'h0003_0000);
    chk1("multu_bubble", out_valid, 1'b0);
    alu(MFHI, 32'd0, 32'd0);
`ifdef ALU_STAGE_MULT_EN
    check("multu_hi", alu_result, 32'd3);
    alu(MFLO, 32'd0, 32'd0);
    check("multu_lo", alu_result, 32'd0);
    alu(MULT, 32'hFFFF_FFFF, 32'd2);
    alu(MFHI, 32'd0, 32'd0);
    check("mult_hi", alu_result, 32'hFFFF_FFFF);
    alu(MFLO, 32'd0, 32'd0);
    check("mult_lo", alu_result, 32'hFFFF_FFFE);
`else
    check("multu_off_hi", alu_result, 32'h11);
    alu(MFLO, 32'd0, 32'd0);
    check("multu_off_lo", alu_result, 32'h22);
`endif

    repeat (2) @(negedge clk);
    en_cmp = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
